// File: rtl/div_16x8_seq.sv
// Sequential 16/8 unsigned restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Optional divide-by-zero flag port enabled by defining DIV_DBZ_FLAG_EN.
module div_16x8_seq (
  input  logic        clk_div16x8,
  input  logic        rst,
  input  logic        vld_in,
  output logic        rdy_in,
  input  logic [15:0] a,
  input  logic [7:0]  b,
  output logic        vld_out,
  input  logic        rdy_out,
  output logic [15:0] quot,
  output logic [7:0]  rem,
`ifdef DIV_DBZ_FLAG_EN
  output logic        dbz,
`endif
  output logic [1:0]  dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // a producer holds valid (and its data) until that edge, and ready never depends on valid.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] a_r;
  logic [7:0]  b_r;
  logic [7:0]  pr;
  logic [15:0] q;
  logic [3:0]  cnt;

  logic [8:0]  shifted;
  logic        fits;
  logic [8:0]  pr_next;

  assign dbg_state = state;

  // Partial remainder is always < b, so 8 bits hold it; the shifted value needs 9.
  always_comb begin
    shifted = {pr, a_r[15]};
    fits    = (shifted >= {1'b0, b_r});
    pr_next = fits ? (shifted - {1'b0, b_r}) : shifted;
  end

  always_ff @(posedge clk_div16x8) begin
    if (rst) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      pr      <= '0;
      q       <= '0;
      cnt     <= '0;
      rdy_in  <= 1'b1;
      vld_out <= 1'b0;
      quot    <= '0;
      rem     <= '0;
`ifdef DIV_DBZ_FLAG_EN
      dbz     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (vld_in) begin
            a_r    <= a;
            b_r    <= b;
            pr     <= '0;
            q      <= '0;
            rdy_in <= 1'b0;
            if (b == 8'd0) begin
              state   <= DONE;
              vld_out <= 1'b1;
              quot    <= 16'hFFFF;
              rem     <= a[7:0];
`ifdef DIV_DBZ_FLAG_EN
              dbz     <= 1'b1;
`endif
            end else begin
              state <= BUSY;
              cnt   <= 4'd15;
            end
          end
        end
        BUSY: begin
          // Dividend shifts left so its current MSB is always bit i of the original.
          a_r <= {a_r[14:0], 1'b0};
          pr  <= pr_next[7:0];
          q   <= {q[14:0], fits};
          cnt <= cnt - 4'd1;
          if (cnt == 4'd0) begin
            state   <= DONE;
            vld_out <= 1'b1;
            quot    <= {q[14:0], fits};
            rem     <= pr_next[7:0];
          end
        end
        DONE: begin
          if (rdy_out) begin
            state   <= IDLE;
            vld_out <= 1'b0;
            rdy_in  <= 1'b1;
            quot    <= '0;
            rem     <= '0;
`ifdef DIV_DBZ_FLAG_EN
            dbz     <= 1'b0;
`endif
          end
        end
        default: begin
          state   <= IDLE;
          rdy_in  <= 1'b1;
          vld_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
